// File: rtl/data_mem_arbiter_if.sv
// OBI-style req/gnt/rvalid bus between a master and the data memory side.
// The master modport drives the request and its attributes; the slave
// modport answers with grant and the one-cycle-late response.
interface data_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic                  req;
    logic                  gnt;
    logic                  rvalid;
    logic                  we;
    logic [3:0]            be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (
        output req, we, be, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, be, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// Two-master round-robin arbiter in front of the data memory.
// m0 is the core LSU data port, m1 the loader/debug port. One request is
// forwarded per cycle; the memory grants combinationally and returns its
// response exactly one cycle later, which is routed back to the issuer.
module data_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    data_mem_arbiter_if.slave    m0,
    data_mem_arbiter_if.slave    m1,
    data_mem_arbiter_if.master   mem,
    output logic                 mem_en_o
);

    // Arbitration / response-tracking state
    logic prio_q, prio_d;   // master that wins when both request
    logic pend_q, pend_d;   // a response is due this cycle
    logic id_q,   id_d;     // master that owns the due response
    logic en_q,   en_d;     // memory enable, rises once after reset

    logic                  sel;
    logic                  mem_req;
    logic                  accept;
    logic                  we_mux;
    logic [3:0]            be_mux;
    logic [ADDR_WIDTH-1:0] addr_mux;
    logic [DATA_WIDTH-1:0] wdata_mux;
    logic                  hit0;
    logic                  hit1;

    // Pick the master for this cycle; a lone requester always wins
    always_comb begin
        sel = 1'b0;
        if (m0.req && m1.req) begin
            sel = prio_q;
        end else if (m1.req) begin
            sel = 1'b1;
        end
        mem_req = (m0.req | m1.req) & en_q;
        accept  = mem_req & mem.gnt;
    end

    // Forward the selected master's attributes; idle cycles show master 0
    always_comb begin
        if (mem_req && sel) begin
            we_mux    = m1.we;
            be_mux    = m1.be;
            addr_mux  = m1.addr;
            wdata_mux = m1.wdata;
        end else begin
            we_mux    = m0.we;
            be_mux    = m0.be;
            addr_mux  = m0.addr;
            wdata_mux = m0.wdata;
        end
    end

    assign mem.req   = mem_req;
    assign mem.we    = we_mux;
    assign mem.be    = be_mux;
    assign mem.addr  = addr_mux;
    assign mem.wdata = wdata_mux;

    // Grant goes only to the selected master, gated by the forwarded request
    always_comb begin
        m0.gnt = accept & ~sel;
        m1.gnt = accept &  sel;
    end

    // Route the returning response to whichever master was granted last cycle
    always_comb begin
        hit0      = pend_q & ~id_q;
        hit1      = pend_q &  id_q;
        m0.rvalid = mem.rvalid & hit0;
        m1.rvalid = mem.rvalid & hit1;
        m0.rdata  = hit0 ? mem.rdata : '0;
        m1.rdata  = hit1 ? mem.rdata : '0;
    end

    // Next state: hand priority to the other master after every accepted
    // transfer and remember who must receive the response next cycle
    always_comb begin
        prio_d = prio_q;
        pend_d = accept;
        id_d   = id_q;
        en_d   = 1'b1;
        if (accept) begin
            prio_d = ~sel;
            id_d   = sel;
        end
    end

    // State registers; reset drops any outstanding response
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= PRIO_RESET;
            pend_q <= 1'b0;
            id_q   <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            prio_q <= prio_d;
            pend_q <= pend_d;
            id_q   <= id_d;
            en_q   <= en_d;
        end
    end

    assign mem_en_o = en_q;

`ifndef SYNTHESIS
    // Flag a memory response that no granted request is waiting for
    always @(posedge clk_i) begin
        if (rst_ni) begin
            assert (!(mem.rvalid && !pend_q))
            else $warning("data_mem_arbiter: stray rvalid with no outstanding request dropped");
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: a one-cycle-latency memory, a transaction
// level model of the arbiter, a per-cycle compare process and directed tests.
module tb_data_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n;
    logic mem_en;

    always #5 clk = ~clk;

    data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m0_if ();
    data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m1_if ();
    data_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mem_if ();

    data_mem_arbiter #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .PRIO_RESET(1'b0)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .m0      (m0_if),
        .m1      (m1_if),
        .mem     (mem_if),
        .mem_en_o(mem_en)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory environment ----------------
    logic [31:0] mem_arr [0:255];
    logic        mem_rv_q = 1'b0;
    logic [31:0] mem_rd_q = 32'h0;
    logic        force_stray;
    logic        pl_we;
    logic [7:0]  pl_idx;
    logic [31:0] pl_data;

    assign mem_if.gnt    = mem_if.req;
    assign mem_if.rvalid = mem_rv_q | force_stray;
    assign mem_if.rdata  = mem_rd_q;

    always @(posedge clk) begin
        mem_rv_q <= mem_if.req & mem_if.gnt;
        if (pl_we) mem_arr[pl_idx] <= pl_data;
        if (mem_if.req & mem_if.gnt) begin
            mem_rd_q <= mem_arr[mem_if.addr[9:2]];
            if (mem_if.we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_if.be[b]) mem_arr[mem_if.addr[9:2]][8*b +: 8] <= mem_if.wdata[8*b +: 8];
            end
        end
    end

    // ---------------- behavioural model ----------------
    int          exp_prio;
    int          exp_owner;   // master owed a response this cycle, -1 none
    logic [31:0] exp_data;
    logic        exp_en;

    function automatic int pick(input logic r0, input logic r1, input int prio);
        if (r0 && r1) return prio;
        if (r1) return 1;
        return 0;
    endfunction

    int          exp_sel;
    logic        exp_req;
    logic [31:0] exp_sel_addr;
    assign exp_sel      = pick(m0_if.req, m1_if.req, exp_prio);
    assign exp_req      = (m0_if.req | m1_if.req) & exp_en;
    assign exp_sel_addr = (exp_sel == 1) ? m1_if.addr : m0_if.addr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_prio  <= 0;
            exp_owner <= -1;
            exp_en    <= 1'b0;
            exp_data  <= 32'h0;
        end else begin
            exp_en <= 1'b1;
            if (exp_req) begin
                exp_prio  <= 1 - exp_sel;
                exp_owner <= exp_sel;
                exp_data  <= mem_arr[exp_sel_addr[9:2]];
            end else begin
                exp_owner <= -1;
            end
        end
    end

    logic        use_m1;
    logic [31:0] x_addr, x_wdata;
    logic [3:0]  x_be;
    logic        x_we;
    assign use_m1  = exp_req && (exp_sel == 1);
    assign x_addr  = use_m1 ? m1_if.addr  : m0_if.addr;
    assign x_wdata = use_m1 ? m1_if.wdata : m0_if.wdata;
    assign x_be    = use_m1 ? m1_if.be    : m0_if.be;
    assign x_we    = use_m1 ? m1_if.we    : m0_if.we;

    int gnt_log [$];
    int rv0_ok = 0;
    int rv1_ok = 0;

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("mem_req", mem_if.req, exp_req);
        chk("mem_en", mem_en, exp_en);
        chk("m0_gnt", m0_if.gnt, exp_req && exp_sel == 0);
        chk("m1_gnt", m1_if.gnt, exp_req && exp_sel == 1);
        chk("mem_addr", mem_if.addr, x_addr);
        chk("mem_wdata", mem_if.wdata, x_wdata);
        chk("mem_be", mem_if.be, x_be);
        chk("mem_we", mem_if.we, x_we);
        chk("m0_rvalid", m0_if.rvalid, mem_if.rvalid && exp_owner == 0);
        chk("m1_rvalid", m1_if.rvalid, mem_if.rvalid && exp_owner == 1);
        chk("m0_rdata", m0_if.rdata, (exp_owner == 0) ? exp_data : 32'h0);
        chk("m1_rdata", m1_if.rdata, (exp_owner == 1) ? exp_data : 32'h0);
        if (m0_if.gnt) gnt_log.push_back(0);
        if (m1_if.gnt) gnt_log.push_back(1);
        if (m0_if.rvalid && m0_if.rdata == 32'h11111111) rv0_ok++;
        if (m1_if.rvalid && m1_if.rdata == 32'h22222222) rv1_ok++;
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input int m, input logic req, input logic we, input logic [3:0] be,
                           input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.be = be; m0_if.addr = addr; m0_if.wdata = wdata;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.be = be; m1_if.addr = addr; m1_if.wdata = wdata;
        end
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        pl_we = 1'b1; pl_idx = idx; pl_data = data;
        tick();
        pl_we = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] seq;
        rst_n = 1'b0;
        force_stray = 1'b0;
        pl_we = 1'b0; pl_idx = 8'h0; pl_data = 32'h0;
        drive_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        preload(8'h08, 32'h11111111);   // 0x20
        preload(8'h09, 32'h22222222);   // 0x24
        preload(8'h0C, 32'h12345678);   // 0x30
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_m0_gnt", m0_if.gnt, 1'b0);
        chk("rst_m0_rdata", m0_if.rdata, 32'h0);

        // release reset, idle three cycles
        rst_n = 1'b1;
        #1 chk("en_before_edge", mem_en, 1'b0);
        tick();
        chk("en_after_edge", mem_en, 1'b1);
        tick(); tick();
        chk("idle_mem_req", mem_if.req, 1'b0);

        // m0 alone: write then read back 0x10
        drive_m(0, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        #1 chk("m0_wr_gnt", m0_if.gnt, 1'b1);
        chk("m0_wr_m1_gnt", m1_if.gnt, 1'b0);
        tick();
        drive_m(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        #1 chk("m0_rd_gnt", m0_if.gnt, 1'b1);
        tick();
        drive_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1 chk("m0_rd_rvalid", m0_if.rvalid, 1'b1);
        chk("m0_rd_data", m0_if.rdata, 32'hDEADBEEF);
        chk("m0_rd_m1_rvalid", m1_if.rvalid, 1'b0);
        tick();

        // m1 partial write to 0x30 (lanes 0-1)
        drive_m(1, 1'b1, 1'b1, 4'b0011, 32'h30, 32'hAAAA5555);
        #1 chk("m1_wr_gnt", m1_if.gnt, 1'b1);
        tick();
        drive_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        chk("mem_0x30", mem_arr[12], 32'h12345555);

        // both request continuously: grants must alternate starting with m0
        gnt_log.delete();
        rv0_ok = 0; rv1_ok = 0;
        drive_m(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        drive_m(1, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
        repeat (6) tick();
        drive_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(); tick();
        chk("alt_count", gnt_log.size(), 6);
        seq = 6'h0;
        for (int i = 0; i < 6 && i < gnt_log.size(); i++) seq[i] = (gnt_log[i] == 1);
        chk("alt_seq", seq, 6'b101010);
        chk("alt_rv0", rv0_ok, 3);
        chk("alt_rv1", rv1_ok, 3);

        // m0 reads back the partially written word
        drive_m(0, 1'b1, 1'b0, 4'hF, 32'h30, 32'h0);
        tick();
        drive_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        #1 chk("m0_30_rvalid", m0_if.rvalid, 1'b1);
        chk("m0_30_rdata", m0_if.rdata, 32'h12345555);
        chk("m0_30_low", m0_if.rdata[15:0], 16'h5555);
        tick();

        // reset right after an m0 read grant; response must be dropped
        drive_m(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        #1 chk("rstmid_gnt", m0_if.gnt, 1'b1);
        tick();
        drive_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        rst_n = 1'b0;
        #1 chk("rstmid_mem_rvalid", mem_if.rvalid, 1'b1);
        chk("rstmid_m0_rvalid", m0_if.rvalid, 1'b0);
        chk("rstmid_m1_rvalid", m1_if.rvalid, 1'b0);
        chk("rstmid_m0_rdata", m0_if.rdata, 32'h0);
        tick();
        rst_n = 1'b1;
        drive_m(0, 1'b1, 1'b0, 4'hF, 32'h20, 32'h0);
        drive_m(1, 1'b1, 1'b0, 4'hF, 32'h24, 32'h0);
        #1 chk("post_rst_no_gnt0", m0_if.gnt, 1'b0);
        chk("post_rst_no_gnt1", m1_if.gnt, 1'b0);
        chk("post_rst_mem_req", mem_if.req, 1'b0);
        tick();
        chk("post_rst_gnt0", m0_if.gnt, 1'b1);
        chk("post_rst_gnt1", m1_if.gnt, 1'b0);
        tick();
        drive_m(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        drive_m(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick(); tick();

        // stray memory response with nothing outstanding
        force_stray = 1'b1;
        #1 chk("stray_m0_rvalid", m0_if.rvalid, 1'b0);
        chk("stray_m1_rvalid", m1_if.rvalid, 1'b0);
        tick();
        force_stray = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
